// File: rtl/mvmpu_job_arbiter.sv
// Round-robin arbiter that shares one MVMPU among REQ_N requesters.
// Each job is picked, its descriptor latched, the MVMPU started once, tracked to completion and reported with a done/err pulse.
module mvmpu_job_arbiter #(
    parameter int REQ_N  = 4,
    parameter int DIMW   = 16,
    parameter int MAW    = 12,
    parameter int VAW    = 10,
    parameter int ACK_TO = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REQ_N-1:0]      req,
    input  logic [REQ_N*DIMW-1:0] req_m,
    input  logic [REQ_N*DIMW-1:0] req_n,
    input  logic [REQ_N*MAW-1:0]  req_addr_m,
    input  logic [REQ_N*VAW-1:0]  req_addr_rv,
    input  logic [REQ_N*VAW-1:0]  req_addr_wv,
    output logic [REQ_N-1:0]      grant,
    output logic [REQ_N-1:0]      done_o,
    output logic [REQ_N-1:0]      err_o,
    output logic                  busy,
    output logic                  mv_start,
    input  logic                  mv_ready,
    output logic [DIMW-1:0]       mv_matrix_m,
    output logic [DIMW-1:0]       mv_matrix_n,
    output logic [MAW-1:0]        mv_addr_rdsm,
    output logic [VAW-1:0]        mv_addr_rdsv,
    output logic [VAW-1:0]        mv_addr_wrsv
);

    localparam int IW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int CW = $clog2(ACK_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic [DIMW-1:0] m;
        logic [DIMW-1:0] n;
        logic [MAW-1:0]  addr_m;
        logic [VAW-1:0]  addr_rv;
        logic [VAW-1:0]  addr_wv;
    } desc_t;

    desc_t [REQ_N-1:0] desc_arr;

    for (genvar g = 0; g < REQ_N; g++) begin : g_unpack
        assign desc_arr[g] = '{m:       req_m[g*DIMW +: DIMW],
                               n:       req_n[g*DIMW +: DIMW],
                               addr_m:  req_addr_m[g*MAW +: MAW],
                               addr_rv: req_addr_rv[g*VAW +: VAW],
                               addr_wv: req_addr_wv[g*VAW +: VAW]};
    end

    state_t           state_q, state_d;
    logic [REQ_N-1:0] grant_q, grant_d, done_q, done_d, err_q, err_d;
    logic             busy_q, busy_d, start_q, start_d;
    desc_t            desc_q, desc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d, owner_q, owner_d;

    logic             pick_vld;
    logic [IW-1:0]    pick_idx;

    // Scan downward so the last hit wins, i.e. the first set bit from ptr upward.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_w    = '0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= REQ_N) idx = idx - REQ_N;
            idx_w = IW'(idx);
            if (req[idx_w]) begin
                pick_vld = 1'b1;
                pick_idx = idx_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
        desc_d  = desc_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld && mv_ready) begin
                    owner_d = pick_idx;
                    if (desc_arr[pick_idx].m != '0 && desc_arr[pick_idx].n != '0) begin
                        desc_d            = desc_arr[pick_idx];
                        grant_d           = '0;
                        grant_d[pick_idx] = 1'b1;
                        start_d           = 1'b1;
                        state_d           = S_LAUNCH;
                    end else begin
                        // Zero-size job: rejected without touching the MVMPU.
                        err_d[pick_idx] = 1'b1;
                        state_d         = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!mv_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TO - 1)) begin
                    grant_d        = '0;
                    err_d[owner_q] = 1'b1;
                    state_d        = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (mv_ready) begin
                    grant_d         = '0;
                    done_d[owner_q] = 1'b1;
                    state_d         = S_FINISH;
                end
            end
            S_FINISH: begin
                ptr_d   = (owner_q == IW'(REQ_N - 1)) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            desc_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            desc_q  <= desc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign grant        = grant_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy         = busy_q;
    assign mv_start     = start_q;
    assign mv_matrix_m  = desc_q.m;
    assign mv_matrix_n  = desc_q.n;
    assign mv_addr_rdsm = desc_q.addr_m;
    assign mv_addr_rdsv = desc_q.addr_rv;
    assign mv_addr_wrsv = desc_q.addr_wv;

endmodule

// File: tb/tb_mvmpu_job_arbiter.sv
// Directed bench for mvmpu_job_arbiter with a small MVMPU ready-handshake model.
module tb_mvmpu_job_arbiter;

    localparam int REQ_N = 4, DIMW = 16, MAW = 12, VAW = 10, ACK_TO = 15;

    logic                  clk, rst;
    logic [REQ_N-1:0]      req;
    logic [REQ_N*DIMW-1:0] req_m, req_n;
    logic [REQ_N*MAW-1:0]  req_addr_m;
    logic [REQ_N*VAW-1:0]  req_addr_rv, req_addr_wv;
    logic [REQ_N-1:0]      grant, done_o, err_o;
    logic                  busy, mv_start, mv_ready;
    logic [DIMW-1:0]       mv_matrix_m, mv_matrix_n;
    logic [MAW-1:0]        mv_addr_rdsm;
    logic [VAW-1:0]        mv_addr_rdsv, mv_addr_wrsv;

    // mode 0: ready from man_ready; 1: drops after start, rises lat cycles later; 2: stuck ready
    int   mode = 0;
    int   lat  = 20;
    int   dl   = 0;
    logic pend = 1'b0, model_ready = 1'b1, man_ready = 1'b1;
    int   tests = 0, fails = 0;

    logic [REQ_N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    assign mv_ready = (mode == 0) ? man_ready : model_ready;

    mvmpu_job_arbiter #(.REQ_N(REQ_N), .DIMW(DIMW), .MAW(MAW), .VAW(VAW), .ACK_TO(ACK_TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_m(req_m), .req_n(req_n),
        .req_addr_m(req_addr_m), .req_addr_rv(req_addr_rv), .req_addr_wv(req_addr_wv),
        .grant(grant), .done_o(done_o), .err_o(err_o), .busy(busy), .mv_start(mv_start),
        .mv_ready(mv_ready), .mv_matrix_m(mv_matrix_m), .mv_matrix_n(mv_matrix_n),
        .mv_addr_rdsm(mv_addr_rdsm), .mv_addr_rdsv(mv_addr_rdsv), .mv_addr_wrsv(mv_addr_wrsv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mode == 1) begin
                if (pend) begin
                    model_ready = 1'b0;
                    dl          = lat;
                    pend        = 1'b0;
                end else if (dl > 0) begin
                    dl = dl - 1;
                    if (dl == 0) model_ready = 1'b1;
                end
                if (mv_start) pend = 1'b1;
            end else begin
                model_ready = 1'b1;
                pend        = 1'b0;
                dl          = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_desc(input int i, input int m, input int n, input int am, input int rv, input int wv);
        req_m[i*DIMW +: DIMW]      = DIMW'(m);
        req_n[i*DIMW +: DIMW]      = DIMW'(n);
        req_addr_m[i*MAW +: MAW]   = MAW'(am);
        req_addr_rv[i*VAW +: VAW]  = VAW'(rv);
        req_addr_wv[i*VAW +: VAW]  = VAW'(wv);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1; req = 4'b1111;
        tick(); tick();
        tests++;
        if ({grant, done_o, err_o, busy, mv_start} !== '0) begin
            fails++; $display("FAIL reset_ctrl: got %h want 0", {grant, done_o, err_o, busy, mv_start});
        end
        tests++;
        if ({mv_matrix_m, mv_matrix_n, mv_addr_rdsm, mv_addr_rdsv, mv_addr_wrsv} !== '0) begin
            fails++; $display("FAIL reset_desc: got %h want 0", {mv_matrix_m, mv_matrix_n, mv_addr_rdsm});
        end
        req = '0; rst = 1'b0;
        tick();
    endtask

    task automatic test_single_job();
        int done_at;
        int starts;
        done_at = -1; starts = 0;
        mode = 1; lat = 20;
        set_desc(0, 8, 16, 'h040, 'h10, 'h20);
        req = 4'b0001;
        tick();
        tests++;
        if (grant !== 4'b0001 || mv_start !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL single_launch: grant=%b start=%b busy=%b want 0001/1/1", grant, mv_start, busy);
        end
        tests++;
        if (mv_matrix_m !== 16'd8 || mv_matrix_n !== 16'd16 || mv_addr_rdsm !== 12'h040 ||
            mv_addr_rdsv !== 10'h10 || mv_addr_wrsv !== 10'h20) begin
            fails++; $display("FAIL single_desc: m=%0d n=%0d am=%h rv=%h wv=%h want 8/16/040/10/20",
                              mv_matrix_m, mv_matrix_n, mv_addr_rdsm, mv_addr_rdsv, mv_addr_wrsv);
        end
        req = '0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (mv_start) starts++;
            if (done_o != '0) begin done_at = c; break; end
        end
        tests++;
        if (done_at != 22 || starts != 0) begin
            fails++; $display("FAIL single_done_time: done_at=%0d starts=%0d want 22/0", done_at, starts);
        end
        tests++;
        if (done_o !== 4'b0001 || grant !== 4'b0000 || err_o !== 4'b0000 || busy !== 1'b1 || mv_matrix_m !== 16'd8) begin
            fails++; $display("FAIL single_finish: done=%b grant=%b err=%b busy=%b m=%0d want 0001/0000/0000/1/8",
                              done_o, grant, err_o, busy, mv_matrix_m);
        end
        tick();
        tests++;
        if (done_o !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000) begin
            fails++; $display("FAIL single_idle: done=%b busy=%b grant=%b want 0000/0/0000", done_o, busy, grant);
        end
    endtask

    task automatic test_round_robin();
        int n_g, n_d, last_d;
        logic [REQ_N-1:0] prev_g;
        n_g = 0; n_d = 0; last_d = 0; prev_g = '0;
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1; lat = 3;
        for (int i = 0; i < REQ_N; i++) set_desc(i, i + 1, i + 2, 'h100 + i, 'h30 + i, 'h60 + i);
        req = 4'b1111;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (grant != '0 && prev_g == '0) begin
                tests++;
                if (n_g > 4 || grant !== exp_g[n_g]) begin
                    fails++; $display("FAIL rr_order: grant #%0d got %b", n_g, grant);
                end
                if (n_g > 0) begin
                    tests++;
                    if (c - last_d != 2) begin
                        fails++; $display("FAIL rr_bubble: gap=%0d want 2", c - last_d);
                    end
                end
                n_g++;
                if (n_g == 5) req = '0;
            end
            if (done_o != '0) begin
                tests++;
                if (done_o !== prev_g || grant !== '0) begin
                    fails++; $display("FAIL rr_done: done=%b grant=%b want done=%b grant=0000", done_o, grant, prev_g);
                end
                n_d++; last_d = c;
                if (n_d == 5) break;
            end
            prev_g = grant;
        end
        tests++;
        if (n_g != 5 || n_d != 5) begin
            fails++; $display("FAIL rr_count: grants=%0d dones=%0d want 5/5", n_g, n_d);
        end
        tick();
    endtask

    task automatic test_zero_dim();
        logic [DIMW-1:0] prev_m;
        int got;
        got = 0;
        mode = 1; lat = 4;
        prev_m = mv_matrix_m;
        set_desc(2, 5, 0, 'h200, 'h01, 'h02);
        set_desc(3, 7, 9, 'h300, 'h03, 'h04);
        req = 4'b0100;
        tick();
        tests++;
        if (err_o !== 4'b0100 || grant !== 4'b0000 || mv_start !== 1'b0 || busy !== 1'b1 || mv_matrix_m !== prev_m) begin
            fails++; $display("FAIL zero_err: err=%b grant=%b start=%b busy=%b m=%0d want 0100/0000/0/1/%0d",
                              err_o, grant, mv_start, busy, mv_matrix_m, prev_m);
        end
        req = 4'b1100;
        tick();
        tests++;
        if (err_o !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000) begin
            fails++; $display("FAIL zero_idle: err=%b busy=%b grant=%b want 0000/0/0000", err_o, busy, grant);
        end
        tick();
        tests++;
        if (grant !== 4'b1000 || mv_start !== 1'b1 || mv_matrix_m !== 16'd7) begin
            fails++; $display("FAIL zero_next: grant=%b start=%b m=%0d want 1000/1/7", grant, mv_start, mv_matrix_m);
        end
        req = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done_o != '0) begin got = 1; break; end
        end
        tests++;
        if (got != 1 || done_o !== 4'b1000) begin
            fails++; $display("FAIL zero_next_done: seen=%0d done=%b want 1/1000", got, done_o);
        end
        tick();
    endtask

    task automatic test_ack_timeout();
        int err_at;
        err_at = -1;
        mode = 2;
        set_desc(1, 2, 3, 'h111, 'h11, 'h12);
        req = 4'b0010;
        tick();
        tests++;
        if (grant !== 4'b0010 || mv_start !== 1'b1) begin
            fails++; $display("FAIL to_launch: grant=%b start=%b want 0010/1", grant, mv_start);
        end
        req = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (err_o != '0 || done_o != '0) begin err_at = c; break; end
        end
        tests++;
        if (err_at != ACK_TO + 1 || err_o !== 4'b0010 || done_o !== 4'b0000 || grant !== 4'b0000) begin
            fails++; $display("FAIL to_err: at=%0d err=%b done=%b grant=%b want %0d/0010/0000/0000",
                              err_at, err_o, done_o, grant, ACK_TO + 1);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || err_o !== 4'b0000) begin
            fails++; $display("FAIL to_idle: busy=%b err=%b want 0/0000", busy, err_o);
        end
    endtask

    task automatic test_reset_mid_job();
        int bad;
        bad = 0;
        mode = 0; man_ready = 1'b1;
        req = 4'b0001;
        tick();
        tests++;
        if (grant !== 4'b0001) begin
            fails++; $display("FAIL rst_mid_grant: got %b want 0001", grant);
        end
        req = '0; man_ready = 1'b0;
        tick(); tick();
        tests++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            fails++; $display("FAIL rst_mid_wait: grant=%b busy=%b want 0001/1", grant, busy);
        end
        rst = 1'b1;
        tick();
        tests++;
        if ({grant, done_o, err_o, busy, mv_start} !== '0 || mv_matrix_m !== '0 || mv_addr_wrsv !== '0) begin
            fails++; $display("FAIL rst_mid_clear: ctrl=%h m=%0d wv=%h want 0", {grant, done_o, err_o, busy, mv_start},
                              mv_matrix_m, mv_addr_wrsv);
        end
        rst = 1'b0; man_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done_o != '0 || err_o != '0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL rst_mid_nodone: %0d stray pulses want 0", bad);
        end
        set_desc(1, 4, 4, 'h0aa, 'h0b, 'h0c);
        set_desc(3, 6, 6, 'h0dd, 'h0e, 'h0f);
        req = 4'b1010;
        tick();
        tests++;
        if (grant !== 4'b0010) begin
            fails++; $display("FAIL rst_mid_regrant: got %b want 0010", grant);
        end
        req = '0; man_ready = 1'b0;
        tick(); tick();
        man_ready = 1'b1;
        tick();
        tests++;
        if (done_o !== 4'b0010) begin
            fails++; $display("FAIL rst_mid_done: got %b want 0010", done_o);
        end
        tick();
    endtask

    task automatic test_hold_inflight();
        mode = 0; man_ready = 1'b0;
        set_desc(0, 3, 4, 'h050, 'h15, 'h25);
        req = 4'b0001;
        tick(); tick();
        tests++;
        if (grant !== 4'b0000 || busy !== 1'b0 || mv_start !== 1'b0) begin
            fails++; $display("FAIL hold_nogrant: grant=%b busy=%b start=%b want 0000/0/0", grant, busy, mv_start);
        end
        man_ready = 1'b1;
        tick();
        tests++;
        if (grant !== 4'b0001 || mv_start !== 1'b1 || mv_matrix_m !== 16'd3) begin
            fails++; $display("FAIL hold_grant: grant=%b start=%b m=%0d want 0001/1/3", grant, mv_start, mv_matrix_m);
        end
        set_desc(0, 99, 77, 'h777, 'h3f, 'h3e);
        req = '0; man_ready = 1'b0;
        tick(); tick();
        tests++;
        if (mv_matrix_m !== 16'd3 || mv_matrix_n !== 16'd4 || mv_addr_rdsm !== 12'h050 || grant !== 4'b0001) begin
            fails++; $display("FAIL inflight_desc: m=%0d n=%0d am=%h grant=%b want 3/4/050/0001",
                              mv_matrix_m, mv_matrix_n, mv_addr_rdsm, grant);
        end
        man_ready = 1'b1;
        tick();
        tests++;
        if (done_o !== 4'b0001 || mv_matrix_m !== 16'd3) begin
            fails++; $display("FAIL inflight_done: done=%b m=%0d want 0001/3", done_o, mv_matrix_m);
        end
        tick();
        tests++;
        if (done_o !== 4'b0000 || busy !== 1'b0 || mv_matrix_m !== 16'd3 || mv_addr_rdsv !== 10'h15) begin
            fails++; $display("FAIL after_hold: done=%b busy=%b m=%0d rv=%h want 0000/0/3/15",
                              done_o, busy, mv_matrix_m, mv_addr_rdsv);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; req_m = '0; req_n = '0;
        req_addr_m = '0; req_addr_rv = '0; req_addr_wv = '0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_zero_dim();
        test_ack_timeout();
        test_reset_mid_job();
        test_hold_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
